// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: FSM state encoding, default bus widths
// and the round-robin pointer wrap helper.
package vram_arbiter_pkg;

   localparam int unsigned VRAM_ADDR_WIDTH = 16;
   localparam int unsigned VRAM_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } vram_state_e;

   // Next round-robin start point after port 'win' is served; wraps N-1 -> 1.
   function automatic int unsigned rr_next(int unsigned win, int unsigned num_ports);
      return (win + 1 >= num_ports) ? 1 : win + 1;
   endfunction

endpackage

// File: rtl/vram_rr_picker.sv
// Combinational round-robin priority encoder over ports 1..NUM_PORTS-1.
// Scans upward from rr_ptr and wraps from NUM_PORTS-1 back to 1; port 0 is ignored.
module vram_rr_picker
   import vram_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req_vec,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic [IDX_W-1:0]     winner,
   output logic                 valid
);

   logic [IDX_W-1:0] idx;

   // First requesting port at or after rr_ptr, within the 1..N-1 ring.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_PORTS - 1; k++) begin
         idx = IDX_W'(((32'(rr_ptr) + k - 1) % (NUM_PORTS - 1)) + 1);
         if (!valid && req_vec[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// N-port arbiter and timing sequencer for the external asynchronous VRAM.
// Port 0 has fixed priority bounded by a burst limit; ports 1..N-1 share round-robin.
// Every output is registered; next values are decoded from the next state.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PORTS    = 2,
   parameter int unsigned ADDR_WIDTH   = VRAM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = VRAM_DATA_WIDTH,
   parameter int unsigned WAIT_CYCLES  = 1,
   parameter int unsigned MAX_P0_BURST = 4
) (
   input  logic                               clk,
   input  logic                               _reset,
   input  logic [NUM_PORTS-1:0]               req,
   input  logic [NUM_PORTS-1:0]               wr,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  be,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata,
   output logic [NUM_PORTS-1:0]               ack,
   output logic [DATA_WIDTH-1:0]              rdata,
   output logic                               busy,
   output logic                               _vram_en,
   output logic                               _vram_rd,
   output logic                               _vram_wr,
   output logic [DATA_WIDTH/8-1:0]            _vram_be,
   output logic [ADDR_WIDTH-1:0]              vram_addr,
   output logic [DATA_WIDTH-1:0]              vram_data_out,
   output logic                               vram_data_oe,
   input  logic [DATA_WIDTH-1:0]              vram_data_in
);

   localparam int unsigned IDX_W = $clog2(NUM_PORTS);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned CNT_W = $clog2(MAX_P0_BURST + 2);

   vram_state_e              state_q, state_d;
   logic [3:0]               wait_q, wait_d;
   logic [IDX_W-1:0]         sel_q, sel_d;
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]         p0_count_q, p0_count_d;
   logic                     en_q, en_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d, busy_q, busy_d;
   logic [BE_W-1:0]          be_q, be_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    dout_q, dout_d, rdata_q, rdata_d;
   logic [NUM_PORTS-1:0]     ack_q, ack_d;

   logic                     others, p0_win, rr_valid;
   logic [IDX_W-1:0]         rr_win, win;
   logic                     w_wr;
   logic [BE_W-1:0]          w_be;
   logic [ADDR_WIDTH-1:0]    w_addr;
   logic [DATA_WIDTH-1:0]    w_data;

   vram_rr_picker #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_picker (
      .req_vec (req),
      .rr_ptr  (rr_ptr_q),
      .winner  (rr_win),
      .valid   (rr_valid)
   );

   // Winner selection and mux of the winning port's command.
   always_comb begin
      others = |req[NUM_PORTS-1:1];
      p0_win = req[0] && !((p0_count_q == CNT_W'(MAX_P0_BURST)) && others);
      win    = p0_win ? '0 : rr_win;
      w_wr   = 1'b0;
      w_be   = '0;
      w_addr = '0;
      w_data = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (win == IDX_W'(p)) begin
            w_wr   = wr[p];
            w_be   = be[p*BE_W +: BE_W];
            w_addr = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            w_data = wdata[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next state plus next values of the registered bus outputs.
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      sel_d      = sel_q;
      rr_ptr_d   = rr_ptr_q;
      p0_count_d = p0_count_q;
      en_d       = 1'b1;
      rd_d       = 1'b1;
      wr_d       = 1'b1;
      oe_d       = 1'b0;
      be_d       = '1;
      addr_d     = addr_q;
      dout_d     = dout_q;
      rdata_d    = rdata_q;
      ack_d      = '0;
      unique case (state_q)
         StIdle: begin
            if (p0_win || rr_valid) begin
               state_d = StAccess;
               wait_d  = 4'(WAIT_CYCLES);
               sel_d   = win;
               en_d    = 1'b0;
               rd_d    = w_wr;
               wr_d    = ~w_wr;
               oe_d    = w_wr;
               be_d    = ~w_be;
               addr_d  = w_addr;
               if (w_wr) dout_d = w_data;
               if (p0_win) begin
                  if (!others) begin
                     p0_count_d = '0;
                  end else if (p0_count_q != CNT_W'(MAX_P0_BURST)) begin
                     p0_count_d = p0_count_q + 1'b1;
                  end
               end else begin
                  p0_count_d = '0;
                  rr_ptr_d   = IDX_W'(rr_next(32'(rr_win), NUM_PORTS));
               end
            end
         end
         StAccess: begin
            if (wait_q == 4'd0) begin
               state_d    = StDone;
               ack_d[sel_q] = 1'b1;
               if (!rd_q) rdata_d = vram_data_in;
            end else begin
               // Hold the strobes as launched in IDLE for the remaining wait states.
               wait_d = wait_q - 1'b1;
               en_d   = 1'b0;
               rd_d   = rd_q;
               wr_d   = wr_q;
               oe_d   = oe_q;
               be_d   = be_q;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   // State and output registers; reset aborts any access immediately.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q    <= StIdle;
         wait_q     <= '0;
         sel_q      <= '0;
         rr_ptr_q   <= IDX_W'(1);
         p0_count_q <= '0;
         en_q       <= 1'b1;
         rd_q       <= 1'b1;
         wr_q       <= 1'b1;
         oe_q       <= 1'b0;
         be_q       <= '1;
         addr_q     <= '0;
         dout_q     <= '0;
         rdata_q    <= '0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         sel_q      <= sel_d;
         rr_ptr_q   <= rr_ptr_d;
         p0_count_q <= p0_count_d;
         en_q       <= en_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         oe_q       <= oe_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         rdata_q    <= rdata_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
      end
   end

   assign _vram_en      = en_q;
   assign _vram_rd      = rd_q;
   assign _vram_wr      = wr_q;
   assign _vram_be      = be_q;
   assign vram_addr     = addr_q;
   assign vram_data_out = dout_q;
   assign vram_data_oe  = oe_q;
   assign ack           = ack_q;
   assign rdata         = rdata_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: 3 ports, one wait state, burst limit 4,
// with a behavioural asynchronous SRAM on the pad side.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        _reset;
   logic [2:0]  req, wr, ack;
   logic [5:0]  be;
   logic [47:0] addr, wdata;
   logic [15:0] rdata, vram_addr, vram_data_out, vram_data_in;
   logic        busy, _vram_en, _vram_rd, _vram_wr, vram_data_oe;
   logic [1:0]  _vram_be;

   logic        ld_en;
   logic [15:0] ld_a, ld_d;
   logic [15:0] mem [0:65535];

   int total = 0;
   int bad   = 0;

   vram_arbiter #(
      .NUM_PORTS    (3),
      .ADDR_WIDTH   (16),
      .DATA_WIDTH   (16),
      .WAIT_CYCLES  (1),
      .MAX_P0_BURST (4)
   ) dut (
      .clk           (clk),
      ._reset        (_reset),
      .req           (req),
      .wr            (wr),
      .be            (be),
      .addr          (addr),
      .wdata         (wdata),
      .ack           (ack),
      .rdata         (rdata),
      .busy          (busy),
      ._vram_en      (_vram_en),
      ._vram_rd      (_vram_rd),
      ._vram_wr      (_vram_wr),
      ._vram_be      (_vram_be),
      .vram_addr     (vram_addr),
      .vram_data_out (vram_data_out),
      .vram_data_oe  (vram_data_oe),
      .vram_data_in  (vram_data_in)
   );

   always #5 clk = ~clk;

   // SRAM model: byte-masked write while enabled+write strobe low, async read.
   always @(posedge clk) begin
      if (ld_en) begin
         mem[ld_a] <= ld_d;
      end else if (!_vram_en && !_vram_wr) begin
         if (!_vram_be[0]) mem[vram_addr][7:0]  <= vram_data_out[7:0];
         if (!_vram_be[1]) mem[vram_addr][15:8] <= vram_data_out[15:8];
      end
   end
   assign vram_data_in = (!_vram_en && !_vram_rd) ? mem[vram_addr] : 16'h0000;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      ld_a  = a;
      ld_d  = d;
      ld_en = 1'b1;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic pulse_reset();
      req    = '0;
      _reset = 1'b0;
      tick();
      tick();
      _reset = 1'b1;
      tick();
   endtask

   // One access on port p; reports cycles to ack and strobe activity seen on the way.
   task automatic do_access(input int p, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input logic [1:0] b,
                            output int lat, output int en_lo, output int rd_lo,
                            output int wr_lo, output int oe_hi,
                            output logic [1:0] be_seen, output logic [15:0] rd_val);
      wr[p]             = w;
      addr[p*16 +: 16]  = a;
      wdata[p*16 +: 16] = d;
      be[p*2 +: 2]      = b;
      req[p]            = 1'b1;
      lat = 0; en_lo = 0; rd_lo = 0; wr_lo = 0; oe_hi = 0;
      be_seen = 'x;
      rd_val  = 'x;
      for (int i = 0; i < 20; i++) begin
         tick();
         lat++;
         if (!_vram_en) begin en_lo++; be_seen = _vram_be; end
         if (!_vram_rd) rd_lo++;
         if (!_vram_wr) wr_lo++;
         if (vram_data_oe) oe_hi++;
         if (ack[p]) begin rd_val = rdata; break; end
      end
      if (!ack[p]) lat = 99;
      req[p] = 1'b0;
   endtask

   int          lat, en_lo, rd_lo, wr_lo, oe_hi, n, t, a1, a2;
   logic [1:0]  be_seen;
   logic [15:0] rd_val;
   logic        seen_ack;
   int          grants [0:5];
   int          exp_rr [0:5];
   int          exp_st [0:5];

   initial begin
      exp_rr = '{0, 1, 2, 1, 2, 1};
      exp_st = '{0, 0, 0, 0, 1, 0};
      req = '0; wr = '0; be = '0; addr = '0; wdata = '0;
      ld_en = 1'b0; ld_a = '0; ld_d = '0;
      _reset = 1'b0;
      #12;
      chk("rst_en", _vram_en, 1);
      chk("rst_rd", _vram_rd, 1);
      chk("rst_wr", _vram_wr, 1);
      chk("rst_be", _vram_be, 2'b11);
      chk("rst_addr", vram_addr, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_oe", vram_data_oe, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      preload(16'h1234, 16'hBEEF);
      preload(16'h0042, 16'h1100);
      preload(16'h0077, 16'h6666);
      preload(16'h0010, 16'h0000);
      _reset = 1'b1;
      tick();

      // Single read on port 1.
      do_access(1, 1'b0, 16'h1234, 16'h0, 2'b11, lat, en_lo, rd_lo, wr_lo, oe_hi, be_seen, rd_val);
      chk("rd_lat", lat, 3);
      chk("rd_strobe", rd_lo, 2);
      chk("rd_nowr", wr_lo, 0);
      chk("rd_data", rd_val, 16'hBEEF);
      tick();
      chk("rd_ack_pulse", ack, 0);
      chk("rd_idle_busy", busy, 0);

      // Low-byte write on port 0.
      do_access(0, 1'b1, 16'h0042, 16'hA55A, 2'b01, lat, en_lo, rd_lo, wr_lo, oe_hi, be_seen,
                rd_val);
      chk("wr_lat", lat, 3);
      chk("wr_strobe", wr_lo, 2);
      chk("wr_oe", oe_hi, 2);
      chk("wr_be", be_seen, 2'b10);
      chk("wr_oe_done", vram_data_oe, 0);
      chk("wr_mem", mem[16'h0042], 16'h115A);
      chk("wr_rdata_hold", rdata, 16'hBEEF);
      tick();

      // Zero byte enables still run a full strobe cycle.
      do_access(2, 1'b1, 16'h0077, 16'h1234, 2'b00, lat, en_lo, rd_lo, wr_lo, oe_hi, be_seen,
                rd_val);
      chk("be0_lat", lat, 3);
      chk("be0_en", en_lo, 2);
      chk("be0_be", be_seen, 2'b11);
      chk("be0_mem", mem[16'h0077], 16'h6666);
      tick();

      // Request withdrawn before it is sampled.
      req[2] = 1'b1;
      #2;
      req[2] = 1'b0;
      tick(); tick(); tick();
      chk("drop_busy", busy, 0);
      chk("drop_en", _vram_en, 1);

      // Back-to-back write then read on port 1.
      wr[1] = 1'b1; addr[31:16] = 16'h0010; wdata[31:16] = 16'h1357; be[3:2] = 2'b11;
      req[1] = 1'b1;
      a1 = -1; a2 = -1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (ack[1] && a1 < 0) begin
            a1 = c;
            chk("b2b_done_oe", vram_data_oe, 0);
            chk("b2b_done_en", _vram_en, 1);
            wr[1] = 1'b0;
         end else if (ack[1]) begin
            a2 = c;
            rd_val = rdata;
            req[1] = 1'b0;
            break;
         end
      end
      req[1] = 1'b0;
      chk("b2b_spacing", a2 - a1, 4);
      chk("b2b_rdata", rd_val, 16'h1357);
      tick();

      // Request dropped during ACCESS still completes.
      wr[2] = 1'b0; addr[47:32] = 16'h0042; be[5:4] = 2'b11; req[2] = 1'b1;
      tick();
      req[2] = 1'b0;
      lat = 99;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (ack[2]) begin lat = c + 2; rd_val = rdata; break; end
      end
      chk("late_drop_lat", lat, 3);
      chk("late_drop_data", rd_val, 16'h115A);
      tick();

      // Reset during the second ACCESS cycle.
      wr[1] = 1'b0; addr[31:16] = 16'h1234; req[1] = 1'b1;
      tick();
      tick();
      chk("mid_in_access", _vram_rd, 0);
      #2;
      _reset = 1'b0;
      #1;
      chk("mid_en", _vram_en, 1);
      chk("mid_rd", _vram_rd, 1);
      chk("mid_oe", vram_data_oe, 0);
      chk("mid_busy", busy, 0);
      chk("mid_rdata", rdata, 0);
      seen_ack = ack[1];
      tick(); seen_ack |= ack[1];
      tick(); seen_ack |= ack[1];
      chk("mid_no_ack", seen_ack, 0);
      req[1] = 1'b0;
      _reset = 1'b1;
      tick();
      do_access(1, 1'b0, 16'h1234, 16'h0, 2'b11, lat, en_lo, rd_lo, wr_lo, oe_hi, be_seen, rd_val);
      chk("post_rst_lat", lat, 3);
      chk("post_rst_data", rd_val, 16'hBEEF);
      tick();

      // Simultaneous requests: port 0 once, ports 1 and 2 held.
      pulse_reset();
      wr = '0; be = '1; addr = {16'h1234, 16'h1234, 16'h1234};
      req = 3'b111;
      n = 0;
      for (int i = 0; i < 6; i++) grants[i] = -1;
      for (int c = 0; c < 100 && n < 6; c++) begin
         tick();
         if (ack != 0) begin
            t = ack[0] ? 0 : (ack[1] ? 1 : 2);
            grants[n] = t;
            n++;
            if (ack[0]) req[0] = 1'b0;
         end
      end
      req = '0;
      for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), grants[i], exp_rr[i]);
      tick(); tick();

      // Starvation limit: port 0 continuous, port 1 pending once.
      pulse_reset();
      req = 3'b011;
      n = 0;
      for (int i = 0; i < 6; i++) grants[i] = -1;
      for (int c = 0; c < 100 && n < 6; c++) begin
         tick();
         if (ack != 0) begin
            t = ack[0] ? 0 : (ack[1] ? 1 : 2);
            grants[n] = t;
            n++;
            if (ack[1]) req[1] = 1'b0;
         end
      end
      req = '0;
      for (int i = 0; i < 6; i++) chk($sformatf("starve_grant%0d", i), grants[i], exp_st[i]);
      tick(); tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
